// File: rtl/serial_sub_pkg.sv
// Shared types and limits for the bit-serial subtractor.
package serial_sub_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} ss_state_t;

    localparam int W_MAX = 32;
endpackage

// File: rtl/serial_sub_fsc.sv
// Full-subtractor cell: d = x - y - bi, with borrow-out bo.
module fsc (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);
    assign d  = x ^ y ^ bi;
    assign bo = (~x & y) | (~x & bi) | (y & bi);
endmodule

// File: rtl/serial_sub.sv
// Bit-serial W-bit subtractor (diff = a - b), LSB first, one bit per clock,
// behind a start/busy/done handshake.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] diff,
    output logic         borrow
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    if (W < 2 || W > W_MAX) begin : g_bad_w
        $error("serial_sub: W out of range");
    end

    ss_state_t     state, state_nxt;
    logic [W-1:0]  sa, sb, sd;
    logic [CW-1:0] cnt;
    logic          bff;
    logic          d_bit, bo_bit;
    logic          load, last;

    // Start is only honoured between operations; RUN ignores it entirely.
    assign load = start && (state == IDLE || state == DONE);
    assign last = (state == RUN) && (cnt == CW'(W - 1));

    fsc u_fsc (
        .x  (sa[0]),
        .y  (sb[0]),
        .bi (bff),
        .d  (d_bit),
        .bo (bo_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sa     <= '0;
            sb     <= '0;
            sd     <= '0;
            bff    <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            borrow <= 1'b0;
        end else if (load) begin
            sa  <= a;
            sb  <= b;
            sd  <= '0;
            bff <= 1'b0;
            cnt <= '0;
        end else if (state == RUN) begin
            sd  <= {d_bit, sd[W-1:1]};
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            bff <= bo_bit;
            cnt <= cnt + CW'(1);
            // Outputs are only updated on the edge that enters DONE.
            if (last) begin
                diff   <= {d_bit, sd[W-1:1]};
                borrow <= bo_bit;
            end
        end
    end
endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: vector table, random ops vs. arithmetic model,
// handshake corner cases, and an exhaustive W=4 sweep.
module tb_serial_sub;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         busy, done, borrow;
    logic [W-1:0] diff;

    logic         start4 = 1'b0;
    logic [3:0]   a4 = '0, b4 = '0;
    logic         busy4, done4, borrow4;
    logic [3:0]   diff4;

    int n_checks = 0;
    int n_fail   = 0;

    serial_sub #(.W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .diff(diff), .borrow(borrow)
    );

    serial_sub #(.W(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .diff(diff4), .borrow(borrow4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_diff;
        logic       exp_borrow;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain 9-bit arithmetic; bit 8 is set exactly when a < b.
    function automatic logic [8:0] model(input logic [7:0] x, input logic [7:0] y);
        return {1'b0, x} - {1'b0, y};
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            n_checks++;
            if (busy && done) begin
                n_fail++;
                $display("FAIL busy_done_overlap: got busy=%0b done=%0b expected not both", busy, done);
            end
        end
    end

    // One operation; optionally pulse start with new operands at busy cycle pulse_at.
    task automatic run_op(input string name, input logic [7:0] ta, input logic [7:0] tb,
                          input logic [7:0] ed, input logic eb, input int pulse_at);
        @(negedge clk);
        start = 1'b1; a = ta; b = tb;
        @(posedge clk);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            if (i == 0) begin
                start = 1'b0; a = 8'($urandom); b = 8'($urandom);
            end
            if (i == pulse_at) begin
                start = 1'b1; a = ~ta; b = ~tb;
            end else if (i == pulse_at + 1) begin
                start = 1'b0;
            end
            check({name, "_busy"}, 32'(busy), 32'd1);
            check({name, "_nodone"}, 32'(done), 32'd0);
        end
        @(negedge clk);
        check({name, "_done"}, 32'(done), 32'd1);
        check({name, "_busy_lo"}, 32'(busy), 32'd0);
        check({name, "_diff"}, 32'(diff), 32'(ed));
        check({name, "_borrow"}, 32'(borrow), 32'(eb));
        @(negedge clk);
        check({name, "_pulse1"}, 32'(done), 32'd0);
        check({name, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic run4(input logic [3:0] ta, input logic [3:0] tb);
        bit seen = 1'b0;
        int exp_d, exp_b;
        @(negedge clk);
        start4 = 1'b1; a4 = ta; b4 = tb;
        @(negedge clk);
        start4 = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (done4) seen = 1'b1;
        end
        exp_d = (int'(ta) - int'(tb)) & 15;
        exp_b = (ta < tb) ? 1 : 0;
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL w4_timeout: got no done for a=%0h b=%0h expected done", ta, tb);
        end else begin
            check($sformatf("w4_%0h_%0h", ta, tb), {27'd0, borrow4, diff4}, 32'((exp_b << 4) | exp_d));
        end
    endtask

    initial begin
        vec_t vecs[6];
        logic [8:0] m;
        logic [7:0] ra, rb;

        vecs[0] = '{8'h5A, 8'h3C, 8'h1E, 1'b0};
        vecs[1] = '{8'h00, 8'h01, 8'hFF, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 8'h00, 1'b0};
        vecs[3] = '{8'h80, 8'h01, 8'h7F, 1'b0};
        vecs[4] = '{8'h01, 8'h80, 8'h81, 1'b1};
        vecs[5] = '{8'h00, 8'h00, 8'h00, 1'b0};

        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_borrow", 32'(borrow), 32'd0);
        rst = 1'b0;

        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp_diff, vecs[i].exp_borrow, -10);

        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom); rb = 8'($urandom);
            m  = model(ra, rb);
            run_op($sformatf("rand%0d", i), ra, rb, m[7:0], m[8], -10);
        end

        // start with new operands mid-RUN must be ignored
        run_op("midrun", 8'h5A, 8'h3C, 8'h1E, 1'b0, 3);

        // reset on the 4th RUN cycle discards the op and clears the outputs
        @(negedge clk);
        start = 1'b1; a = 8'h33; b = 8'h11;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        check("rstrun_busy", 32'(busy), 32'd0);
        check("rstrun_done", 32'(done), 32'd0);
        check("rstrun_diff", 32'(diff), 32'd0);
        check("rstrun_borrow", 32'(borrow), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < W + 3; i++) begin
            @(negedge clk);
            check("rstrun_nodone", 32'(done), 32'd0);
        end

        // start held high through DONE: back-to-back ops
        @(negedge clk);
        start = 1'b1; a = 8'h10; b = 8'h20;
        @(posedge clk);
        @(negedge clk);
        a = 8'h20; b = 8'h10;
        for (int i = 0; i < W - 1; i++) @(negedge clk);
        check("b2b_busy_last", 32'(busy), 32'd1);
        @(negedge clk);
        check("b2b_done1", 32'(done), 32'd1);
        check("b2b_diff1", 32'(diff), 32'h0F0);
        check("b2b_borrow1", 32'(borrow), 32'd1);
        @(negedge clk);
        start = 1'b0;
        check("b2b_restart", 32'(busy), 32'd1);
        check("b2b_hold", 32'(diff), 32'h0F0);
        for (int i = 0; i < W - 1; i++) @(negedge clk);
        check("b2b_busy2", 32'(busy), 32'd1);
        @(negedge clk);
        check("b2b_done2", 32'(done), 32'd1);
        check("b2b_diff2", 32'(diff), 32'h010);
        check("b2b_borrow2", 32'(borrow), 32'd0);

        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                run4(4'(x), 4'(y));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
